// File: rtl/xorexec_out_packer.sv
// xorexec_out_packer
//   Pops result bytes from the xorexec output FIFO (show-ahead) and packs BYTES
//   consecutive bytes little-endian into one word, with an XOR checksum of the
//   valid bytes. A flush emits the current partial word. Words are offered on a
//   valid/ready stream; the packer stalls (stops popping) while a word is held.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   ofifo_rdy     FIFO head byte valid
//   ofifo_pop     consume FIFO head at this edge
//   ofifo_odata   FIFO head byte
//   flush         emit the current partial word (ignored when empty or holding)
//   out_valid     held word valid
//   out_ready     downstream accepts held word
//   out_data      packed word, unused upper bytes zero
//   out_chk       XOR of valid bytes
//   out_nbytes    number of valid bytes (1..BYTES)
//   word_cnt      count of accepted words, wraps at 16 bits
module xorexec_out_packer #(
    parameter int unsigned BYTES  = 4,
    parameter int unsigned dwidth = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ofifo_rdy,
    output logic                         ofifo_pop,
    input  logic [dwidth-1:0]            ofifo_odata,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BYTES*dwidth-1:0]      out_data,
    output logic [dwidth-1:0]            out_chk,
    output logic [$clog2(BYTES+1)-1:0]   out_nbytes,
    output logic [15:0]                  word_cnt
);

    localparam int unsigned NW = $clog2(BYTES + 1);

    typedef enum logic [0:0] {StFill, StHold} state_e;

    state_e                    state_q, state_d;
    logic [NW-1:0]             count_q, count_d;
    logic [BYTES*dwidth-1:0]   acc_q, acc_d;
    logic [dwidth-1:0]         chk_q, chk_d;
    logic                      out_valid_q, out_valid_d;
    logic [BYTES*dwidth-1:0]   out_data_q, out_data_d;
    logic [dwidth-1:0]         out_chk_q, out_chk_d;
    logic [NW-1:0]             out_nbytes_q, out_nbytes_d;
    logic [15:0]               word_cnt_q, word_cnt_d;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        acc_d        = acc_q;
        chk_d        = chk_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_chk_d    = out_chk_q;
        out_nbytes_d = out_nbytes_q;
        word_cnt_d   = word_cnt_q;
        // Popping only in FILL means a held word back-pressures the FIFO.
        ofifo_pop    = (state_q == StFill) && ofifo_rdy && !rst;

        unique case (state_q)
            StFill: begin
                if (ofifo_pop) begin
                    for (int unsigned i = 0; i < BYTES; i++) begin
                        if (count_q == NW'(i)) begin
                            acc_d[i*dwidth +: dwidth] = ofifo_odata;
                        end
                    end
                    chk_d   = chk_q ^ ofifo_odata;
                    count_d = count_q + NW'(1);
                end
                // A flush coinciding with a pop includes that byte; an empty flush is dropped.
                if ((ofifo_pop && count_q == NW'(BYTES - 1)) ||
                    (flush && (ofifo_pop || count_q != '0))) begin
                    out_valid_d  = 1'b1;
                    out_data_d   = acc_d;
                    out_chk_d    = chk_d;
                    out_nbytes_d = count_d;
                    state_d      = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    count_d     = '0;
                    acc_d       = '0;
                    chk_d       = '0;
                    word_cnt_d  = word_cnt_q + 16'd1;
                    state_d     = StFill;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StFill;
            count_q      <= '0;
            acc_q        <= '0;
            chk_q        <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_chk_q    <= '0;
            out_nbytes_q <= '0;
            word_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            acc_q        <= acc_d;
            chk_q        <= chk_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_chk_q    <= out_chk_d;
            out_nbytes_q <= out_nbytes_d;
            word_cnt_q   <= word_cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_chk    = out_chk_q;
    assign out_nbytes = out_nbytes_q;
    assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_xorexec_out_packer.sv
// Directed and random bench for xorexec_out_packer: a byte source queue feeds the
// show-ahead FIFO interface, expected words go to a scoreboard queue.
module tb_xorexec_out_packer;

    localparam int unsigned BYTES = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ofifo_rdy;
    logic        ofifo_pop;
    logic [7:0]  ofifo_odata;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_chk;
    logic [2:0]  out_nbytes;
    logic [15:0] word_cnt;

    always #5 clk = ~clk;

    xorexec_out_packer #(.BYTES(BYTES), .dwidth(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .ofifo_rdy  (ofifo_rdy),
        .ofifo_pop  (ofifo_pop),
        .ofifo_odata(ofifo_odata),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_chk    (out_chk),
        .out_nbytes (out_nbytes),
        .word_cnt   (word_cnt)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [7:0]  c;
        logic [2:0]  n;
    } word_t;

    word_t       sb[$];
    logic [7:0]  src[$];
    int          errors = 0;
    int          checks = 0;
    bit          rdy_en;
    logic [15:0] exp_wcnt;
    logic [31:0] m_d;
    logic [7:0]  m_c;
    int          m_n;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input logic [31:0] d, input logic [7:0] c, input logic [2:0] n);
        word_t w;
        w.d = d;
        w.c = c;
        w.n = n;
        sb.push_back(w);
    endtask

    // Transaction-level packer used for the random traffic (full words only).
    task automatic model_add(input logic [7:0] b);
        src.push_back(b);
        m_d[m_n*8 +: 8] = b;
        m_c = m_c ^ b;
        m_n++;
        if (m_n == BYTES) begin
            sb_push(m_d, m_c, 3'(BYTES));
            m_d = '0;
            m_c = '0;
            m_n = 0;
        end
    endtask

    // One clock: drive source, sample before the edge, account pops/accepts after it.
    task automatic tick();
        logic        pop_s;
        logic        acc_s;
        logic [31:0] d_s;
        logic [7:0]  c_s;
        logic [2:0]  n_s;
        word_t       w;
        ofifo_rdy   = rdy_en && (src.size() > 0);
        ofifo_odata = (src.size() > 0) ? src[0] : 8'h00;
        #1;
        if (ofifo_pop && !ofifo_rdy) check("pop_without_rdy", 64'(ofifo_pop), 0);
        pop_s = ofifo_pop;
        acc_s = out_valid && out_ready && !rst;
        d_s   = out_data;
        c_s   = out_chk;
        n_s   = out_nbytes;
        @(posedge clk);
        if (pop_s && !rst) void'(src.pop_front());
        if (acc_s) begin
            exp_wcnt++;
            if (sb.size() == 0) begin
                check("spurious_word", 64'(sb.size()), 1);
            end else begin
                w = sb.pop_front();
                check("word_data", 64'(d_s), 64'(w.d));
                check("word_chk", 64'(c_s), 64'(w.c));
                check("word_nbytes", 64'(n_s), 64'(w.n));
            end
        end
        @(negedge clk);
    endtask

    task automatic wait_src_empty(input int budget);
        int n = 0;
        while (src.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        if (src.size() > 0) check("src_empty_timeout", 64'(src.size()), 0);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((sb.size() > 0 || src.size() > 0 || out_valid) && n < budget) begin
            tick();
            n++;
        end
        if (sb.size() > 0 || src.size() > 0) check("drain_timeout", 64'(sb.size()), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0; rdy_en = 1'b0;
        ofifo_rdy = 1'b0; ofifo_odata = 8'h00;
        exp_wcnt = '0; m_d = '0; m_c = '0; m_n = 0;
        @(negedge clk);
        tick();
        tick();
        check("rst_valid", 64'(out_valid), 0);
        check("rst_pop", 64'(ofifo_pop), 0);
        check("rst_data", 64'(out_data), 0);
        check("rst_chk", 64'(out_chk), 0);
        check("rst_nbytes", 64'(out_nbytes), 0);
        check("rst_word_cnt", 64'(word_cnt), 0);
        rst = 1'b0;

        // T1: one full word straight through
        out_ready = 1'b1; rdy_en = 1'b1;
        src.push_back(8'h01); src.push_back(8'h02); src.push_back(8'h04); src.push_back(8'h08);
        sb_push(32'h08040201, 8'h0F, 3'd4);
        drain(30);
        check("t1_word_cnt", 64'(word_cnt), 1);

        // T2: held word under back-pressure, no pops while holding
        out_ready = 1'b0;
        src.push_back(8'h10); src.push_back(8'h20); src.push_back(8'h30); src.push_back(8'h40);
        src.push_back(8'h50); src.push_back(8'h60); src.push_back(8'h70); src.push_back(8'h80);
        sb_push(32'h40302010, 8'h40, 3'd4);
        sb_push(32'h80706050, 8'hC0, 3'd4);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        if (!out_valid) check("t2_valid_timeout", 64'(out_valid), 1);
        for (int k = 0; k < 5; k++) begin
            check("t2_hold_valid", 64'(out_valid), 1);
            check("t2_hold_data", 64'(out_data), 64'h40302010);
            check("t2_hold_pop", 64'(ofifo_pop), 0);
            tick();
        end
        check("t2_still_valid", 64'(out_valid), 1);
        out_ready = 1'b1;
        drain(40);
        check("t2_word_cnt", 64'(word_cnt), 3);

        // T3: partial word via flush
        src.push_back(8'hAA); src.push_back(8'h55);
        wait_src_empty(20);
        sb_push(32'h000055AA, 8'hFF, 3'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drain(20);

        // T4: empty flush is ignored; flush coincident with a pop includes the byte
        flush = 1'b1;
        tick();
        check("t4_empty_flush_valid", 64'(out_valid), 0);
        tick();
        check("t4_empty_flush_valid2", 64'(out_valid), 0);
        flush = 1'b0;
        check("t4_word_cnt", 64'(word_cnt), 4);
        src.push_back(8'h01); src.push_back(8'h02);
        wait_src_empty(20);
        sb_push(32'h00100201, 8'h13, 3'd3);
        src.push_back(8'h10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drain(20);
        check("t4_word_cnt2", 64'(word_cnt), 5);

        // T5: reset mid-word discards the partial bytes
        src.push_back(8'h5A); src.push_back(8'hA5);
        wait_src_empty(20);
        rst = 1'b1;
        tick();
        check("t5_rst_valid", 64'(out_valid), 0);
        check("t5_rst_data", 64'(out_data), 0);
        check("t5_rst_chk", 64'(out_chk), 0);
        check("t5_rst_nbytes", 64'(out_nbytes), 0);
        check("t5_rst_word_cnt", 64'(word_cnt), 0);
        exp_wcnt = '0;
        rst = 1'b0;
        src.push_back(8'h11); src.push_back(8'h22); src.push_back(8'h33); src.push_back(8'h44);
        sb_push(32'h44332211, 8'h44, 3'd4);
        drain(30);
        check("t5_word_cnt", 64'(word_cnt), 1);

        // T6: word counter wrap, preloaded to 0xFFFF
        force dut.word_cnt_q = 16'hFFFF;
        #1;
        release dut.word_cnt_q;
        check("t6_preload", 64'(word_cnt), 64'hFFFF);
        exp_wcnt = 16'hFFFF;
        model_add(8'hDE); model_add(8'hAD); model_add(8'hBE); model_add(8'hEF);
        drain(30);
        check("t6_wrap", 64'(word_cnt), 0);

        // Random source/sink stress against the scoreboard
        for (int i = 0; i < 48 * BYTES; i++) model_add(8'($urandom_range(0, 255)));
        n = 0;
        while ((sb.size() > 0 || src.size() > 0 || out_valid) && n < 3000) begin
            rdy_en    = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            tick();
            n++;
        end
        if (sb.size() > 0 || src.size() > 0) check("stress_timeout", 64'(sb.size()), 0);
        check("stress_word_cnt", 64'(word_cnt), 64'(exp_wcnt));
        check("stress_word_cnt_abs", 64'(word_cnt), 48);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
